// File: rtl/nmi_arb.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MST masters,
// with a busy watchdog that aborts hung transfers and reports them.
module nmi_arb #(
    parameter int NUM_MST = 2,
    parameter int TIMEOUT = 255,
    parameter int IDW     = $clog2(NUM_MST)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MST-1:0]        m_valid_i,
    input  logic [NUM_MST-1:0][31:0]  m_addr_i,
    input  logic [NUM_MST-1:0][31:0]  m_wdata_i,
    input  logic [NUM_MST-1:0][3:0]   m_wstrb_i,
    output logic [NUM_MST-1:0]        m_ready_o,
    output logic [31:0]               m_rdata_o,
    output logic                      s_valid_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    output logic [3:0]                s_wstrb_o,
    input  logic                      s_ready_i,
    input  logic [31:0]               s_rdata_i,
    input  logic                      err_clr_i,
    output logic                      err_o,
    output logic [IDW-1:0]            err_id_o,
    output logic                      err_irq_o
);

    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [IDW-1:0]  grant_reg;
    logic [IDW-1:0]  last_reg;
    logic [CW-1:0]   cnt_reg;

    logic            busy;
    logic            gnt_valid;
    logic            done;
    logic            tmo;
    logic            any_req;
    logic [IDW-1:0]  winner;

    assign busy      = (state_reg == BUSY);
    assign gnt_valid = m_valid_i[grant_reg];
    assign any_req   = |m_valid_i;

    // A withdrawn request is neither completed nor timed out.
    assign done = busy && gnt_valid && s_ready_i;
    assign tmo  = (TIMEOUT != 0) && busy && gnt_valid && !s_ready_i && (cnt_reg == TMO_VAL);

    assign s_valid_o = busy && gnt_valid;
    assign s_addr_o  = m_addr_i[grant_reg];
    assign s_wdata_o = m_wdata_i[grant_reg];
    assign s_wstrb_o = busy ? m_wstrb_i[grant_reg] : 4'b0000;
    assign m_rdata_o = tmo ? 32'hDEAD_BEEF : s_rdata_i;

    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_ready
            assign m_ready_o[gi] = (done || tmo) && (grant_reg == IDW'(gi));
        end
    endgenerate

    // Scan downward so the requester closest after last_reg overwrites the rest.
    always_comb begin
        winner = last_reg;
        for (int i = NUM_MST; i >= 1; i--) begin
            if (m_valid_i[(int'(last_reg) + i) % NUM_MST]) begin
                winner = IDW'((int'(last_reg) + i) % NUM_MST);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= IDW'(NUM_MST - 1);
            cnt_reg   <= '0;
            err_o     <= 1'b0;
            err_id_o  <= '0;
            err_irq_o <= 1'b0;
        end else begin
            err_irq_o <= tmo;
            if (tmo) begin
                err_o    <= 1'b1;
                err_id_o <= grant_reg;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg <= winner;
                        last_reg  <= winner;
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!gnt_valid || s_ready_i || tmo) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmi_arb.sv
// Bench for nmi_arb: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_nmi_arb;

    localparam int NM  = 2;
    localparam int TMO = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NM-1:0]         m_valid;
    logic [NM-1:0][31:0]   m_addr;
    logic [NM-1:0][31:0]   m_wdata;
    logic [NM-1:0][3:0]    m_wstrb;
    logic                  s_ready;
    logic [31:0]           s_rdata;
    logic                  err_clr;

    logic [NM-1:0]         m_ready_o;
    logic [31:0]           m_rdata_o;
    logic                  s_valid_o;
    logic [31:0]           s_addr_o;
    logic [31:0]           s_wdata_o;
    logic [3:0]            s_wstrb_o;
    logic                  err_o;
    logic [0:0]            err_id_o;
    logic                  err_irq_o;

    logic [NM-1:0]         z_m_ready;
    logic [31:0]           z_m_rdata;
    logic                  z_s_valid;
    logic [31:0]           z_s_addr;
    logic [31:0]           z_s_wdata;
    logic [3:0]            z_s_wstrb;
    logic                  z_err;
    logic [0:0]            z_err_id;
    logic                  z_err_irq;

    int n_checks = 0;
    int n_err    = 0;

    nmi_arb #(.NUM_MST(NM), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o),
        .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata),
        .err_clr_i(err_clr), .err_o(err_o), .err_id_o(err_id_o), .err_irq_o(err_irq_o)
    );

    // Same stimulus, watchdog disabled.
    nmi_arb #(.NUM_MST(NM), .TIMEOUT(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst),
        .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(z_m_ready), .m_rdata_o(z_m_rdata),
        .s_valid_o(z_s_valid), .s_addr_o(z_s_addr), .s_wdata_o(z_s_wdata), .s_wstrb_o(z_s_wstrb),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata),
        .err_clr_i(err_clr), .err_o(z_err), .err_id_o(z_err_id), .err_irq_o(z_err_irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic at_n();
        @(negedge clk);
        #1;
    endtask

    // Slave model: readies after slv_wait valid cycles (never if negative).
    int          slv_wait = 0;
    int          vcnt     = 0;
    logic [31:0] slv_data = 32'h0;
    initial begin
        s_ready = 1'b0;
        s_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            s_rdata = slv_data + 32'(vcnt);
            if (!s_valid_o) begin
                s_ready = 1'b0;
                vcnt    = 0;
            end else begin
                s_ready = (slv_wait >= 0) && (vcnt == slv_wait);
                vcnt++;
            end
        end
    end

    // Reference model: who owns the slave, for how many cycles, and error state.
    bit mb     = 1'b0;
    int mown   = 0;
    int mage   = 0;
    int mlast  = NM - 1;
    bit merr   = 1'b0;
    int merrid = 0;
    bit mirq   = 1'b0;

    function automatic int pick();
        for (int k = 1; k <= NM; k++) begin
            if (m_valid[(mlast + k) % NM]) return (mlast + k) % NM;
        end
        return -1;
    endfunction

    function automatic bit e_sv();
        return mb && m_valid[mown];
    endfunction

    function automatic bit e_tmo();
        return e_sv() && !s_ready && (TMO != 0) && (mage == TMO + 1);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        begin : upd
            bit t;
            int p;
            if (rst) begin
                mb = 0; mown = 0; mage = 0; mlast = NM - 1;
                merr = 0; merrid = 0; mirq = 0;
            end else begin
                t = e_tmo();
                mirq = t;
                if (t) begin
                    merr = 1; merrid = mown;
                end else if (err_clr) begin
                    merr = 0;
                end
                if (mb) begin
                    if (!m_valid[mown] || s_ready || t) mb = 0;
                    else mage++;
                end else begin
                    p = pick();
                    if (p >= 0) begin
                        mb = 1; mown = p; mlast = p; mage = 1;
                    end
                end
            end
        end
    end

    int pulse_cnt = 0;
    int gq[$];

    initial forever begin
        @(negedge clk);
        begin : cmp
            logic [NM-1:0] e_mr;
            bit            fin;
            fin  = (e_sv() && s_ready) || e_tmo();
            e_mr = fin ? NM'(1 << mown) : '0;
            chk("s_valid", s_valid_o, e_sv());
            chk("m_ready", m_ready_o, e_mr);
            chk("m_rdata", m_rdata_o, e_tmo() ? 32'hDEAD_BEEF : s_rdata);
            chk("s_addr",  s_addr_o,  m_addr[mown]);
            chk("s_wdata", s_wdata_o, m_wdata[mown]);
            chk("s_wstrb", s_wstrb_o, mb ? m_wstrb[mown] : 4'h0);
            chk("err",     err_o,     merr);
            chk("err_id",  err_id_o,  merrid);
            chk("err_irq", err_irq_o, mirq);
            if (m_ready_o != '0) begin
                pulse_cnt++;
                for (int k = 0; k < NM; k++) if (m_ready_o[k]) gq.push_back(k);
                $display("txn: m_ready=%b rdata=%h addr=%h t=%0t", m_ready_o, m_rdata_o, s_addr_o, $time);
            end
        end
    end

    int          vc, bc, tpos, z_pulses;
    logic [31:0] trd;
    logic [31:0] trdy;

    task automatic do_tmo(input int m, input logic clr_hold);
        slv_wait = -1;
        bc = 0; tpos = -1; trd = '0; trdy = '0;
        m_addr[m] = 32'h0000_3000 + 32'(m);
        @(posedge clk); #1;
        m_valid[m] = 1'b1;
        err_clr    = clr_hold;
        for (int c = 0; c < 30 && tpos < 0; c++) begin
            at_n();
            if (s_valid_o) bc++;
            if (m_ready_o != '0) begin
                tpos = bc; trd = m_rdata_o; trdy = 32'(m_ready_o);
            end
        end
        @(posedge clk); #1;
        m_valid[m] = 1'b0;
        at_n();
        chk("tmo_err_set", err_o, 1);
        chk("tmo_err_id", err_id_o, m);
        chk("tmo_irq_on", err_irq_o, 1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        at_n();
        chk("tmo_irq_off", err_irq_o, 0);
        chk("tmo_busy_cycle", tpos, TMO + 1);
        chk("tmo_rdata", trd, 32'hDEAD_BEEF);
        chk("tmo_ready", trdy, 32'(1) << m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0; err_clr = 1'b0;
        m_wstrb[0] = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_s_valid", s_valid_o, 0);
        chk("rst_m_ready", m_ready_o, 0);
        chk("rst_s_wstrb", s_wstrb_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single master read, zero-wait slave
        m_addr[1] = 32'h1000_0004; m_wstrb[1] = 4'h0;
        slv_wait = 0; slv_data = 32'h1234_5678;
        @(posedge clk); #1;
        m_valid[1] = 1'b1; pulse_cnt = 0;
        at_n();
        chk("t1_s_valid_req", s_valid_o, 0);
        at_n();
        chk("t1_s_valid", s_valid_o, 1);
        chk("t1_m_ready", m_ready_o, 2'b10);
        chk("t1_rdata", m_rdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        m_valid[1] = 1'b0;
        repeat (3) at_n();
        chk("t1_pulses", pulse_cnt, 1);

        // Round robin with both masters requesting
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
        m_wstrb = '0; slv_data = 32'hA5A5_0000;
        gq.delete();
        @(posedge clk); #1;
        m_valid = 2'b11;
        for (int c = 0; c < 60 && gq.size() < 6; c++) at_n();
        @(posedge clk); #1;
        m_valid = '0;
        chk("t2_count", gq.size() >= 6, 1);
        for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), (k < gq.size()) ? gq[k] : 99, k % 2);

        // Write with three wait states
        m_addr[0] = 32'h0000_2000; m_wdata[0] = 32'hCAFE_F00D; m_wstrb[0] = 4'b0011;
        slv_wait = 3; pulse_cnt = 0; vc = 0;
        @(posedge clk); #1;
        m_valid[0] = 1'b1;
        for (int c = 0; c < 20 && pulse_cnt == 0; c++) begin
            at_n();
            if (s_valid_o) begin
                vc++;
                chk("t3_wdata", s_wdata_o, 32'hCAFE_F00D);
                chk("t3_wstrb", s_wstrb_o, 4'b0011);
            end
        end
        @(posedge clk); #1;
        m_valid[0] = 1'b0;
        at_n(); at_n();
        chk("t3_valid_cycles", vc, 4);
        chk("t3_pulses", pulse_cnt, 1);

        // Timeouts: clear held during abort (set wins), then a plain one
        m_wstrb = '0;
        do_tmo(0, 1'b1);
        do_tmo(1, 1'b0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        at_n();
        chk("clr_err", err_o, 0);
        chk("clr_err_id_kept", err_id_o, 1);

        // Watchdog disabled instance never aborts
        slv_wait = -1; z_pulses = 0;
        @(posedge clk); #1;
        m_valid[0] = 1'b1;
        repeat (1000) begin
            at_n();
            if (z_m_ready != '0) z_pulses++;
        end
        chk("t5_no_abort", z_pulses, 0);
        chk("t5_still_valid", z_s_valid, 1);
        chk("t5_no_err", z_err, 0);
        @(posedge clk); #1;
        m_valid[0] = 1'b0;
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        repeat (2) at_n();

        // Master 1 withdraws in its second busy cycle
        slv_wait = -1; m_wstrb[1] = 4'hF; pulse_cnt = 0;
        @(posedge clk); #1;
        m_valid[1] = 1'b1;
        at_n();
        chk("t6_s_valid_req", s_valid_o, 0);
        at_n();
        chk("t6_s_valid_busy", s_valid_o, 1);
        @(posedge clk); #1;
        m_valid[1] = 1'b0;
        #2;
        chk("t6_s_valid_drop", s_valid_o, 0);
        chk("t6_m_ready_drop", m_ready_o, 0);
        at_n(); at_n();
        chk("t6_idle_wstrb", s_wstrb_o, 0);
        at_n();
        chk("t6_pulses", pulse_cnt, 0);
        chk("t6_no_err", err_o, 0);

        // Reset mid-wait, then contention goes to master 0
        m_wstrb[0] = 4'hF; slv_wait = -1;
        @(posedge clk); #1;
        m_valid[0] = 1'b1;
        at_n(); at_n();
        chk("t7_busy", s_valid_o, 1);
        @(posedge clk); #1;
        rst = 1'b1; m_valid = 2'b11;
        #2;
        chk("t7_rst_s_valid", s_valid_o, 0);
        chk("t7_rst_m_ready", m_ready_o, 0);
        chk("t7_rst_s_wstrb", s_wstrb_o, 0);
        chk("t7_rst_err_id", err_id_o, 0);
        chk("t7_rst_irq", err_irq_o, 0);
        @(posedge clk); #1;
        rst = 1'b0; slv_wait = 0; gq.delete();
        for (int c = 0; c < 20 && gq.size() == 0; c++) at_n();
        chk("t7_first_winner", (gq.size() > 0) ? gq[0] : 99, 0);
        @(posedge clk); #1;
        m_valid = '0;
        repeat (3) at_n();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
